// File: rtl/ula_feeder.sv
// Command FIFO feeding a fixed-latency ULA stage: issues one {op,a,b} at a time,
// waits ALU_LAT cycles, captures the result and holds it until res_ready.
module ula_feeder #(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   output logic [2:0] alu_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_s,
   input  logic       alu_flag,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_s,
   output logic       res_flag,
   output logic [2:0] res_op,
   output logic [2:0] count,
   output logic       busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t          state, state_nxt;
   logic [18:0]     mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]   lat_cnt;
   logic            push, pop, capture;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) ptr_inc = '0;
      else                     ptr_inc = p + 1'b1;
   endfunction

   // cmd_ready is gated by rst_n so it drops the instant reset asserts
   assign cmd_ready = rst_n && (count < 3'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign res_valid = (state == HOLD);
   assign busy      = (count != 3'd0) || (state != IDLE);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (count != 3'd0) begin
               pop       = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               capture   = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (res_ready) begin
               if (count != 3'd0) begin
                  pop       = 1'b1;
                  state_nxt = WAIT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 3'd0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage carries no reset; occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op  <= 3'd0;
         alu_a   <= 8'd0;
         alu_b   <= 8'd0;
         lat_cnt <= '0;
      end else begin
         if (pop) begin
            {alu_op, alu_a, alu_b} <= mem[rd_ptr];
            lat_cnt                <= LW'(ALU_LAT);
         end else if (state == WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_s    <= 8'd0;
         res_flag <= 1'b0;
         res_op   <= 3'd0;
      end else if (capture) begin
         res_s    <= alu_s;
         res_flag <= alu_flag;
         res_op   <= alu_op;
      end
   end

endmodule

// File: tb/tb_ula_feeder.sv
// Scoreboard bench for ula_feeder with a registered one-cycle ALU model.
module tb_ula_feeder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] cmd_a = 8'd0, cmd_b = 8'd0;
   logic [2:0] alu_op;
   logic [7:0] alu_a, alu_b;
   logic [7:0] alu_s = 8'd0;
   logic       alu_flag = 1'b0;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [7:0] res_s;
   logic       res_flag;
   logic [2:0] res_op;
   logic [2:0] count;
   logic       busy;

   typedef struct {
      logic [2:0] op;
      logic [7:0] s;
      logic       flag;
   } exp_t;

   exp_t exp_q[$];
   int   hs_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   ula_feeder #(.DEPTH(4), .ALU_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_s(alu_s), .alu_flag(alu_flag),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_s(res_s), .res_flag(res_flag), .res_op(res_op),
      .count(count), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // {flag, s}: add gives carry, subtract gives borrow, other ops XOR
   function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int r;
      case (op)
         3'b001:  begin r = int'(a) + int'(b); ref_alu = {r > 255, r[7:0]}; end
         3'b010:  begin r = int'(a) - int'(b); ref_alu = {r < 0, r[7:0]}; end
         default: ref_alu = {1'b0, a ^ b};
      endcase
   endfunction

   always @(posedge clk) {alu_flag, alu_s} <= ref_alu(alu_op, alu_a, alu_b);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Called one step after a rising edge; returns the same way after the accepting edge.
   task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int   n = 0;
      logic ok = 1'b0;
      logic [8:0] r;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      while (!ok && n < 60) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            r  = ref_alu(op, a, b);
            exp_q.push_back('{op: op, s: r[7:0], flag: r[8]});
         end
         sync();
         n++;
      end
      cmd_valid = 1'b0;
      if (!ok) check("push_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_drain(input int max_cyc);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      sync();
   endtask

   // Monitor: compares each handshaken result and checks HOLD stability
   logic       prev_valid = 1'b0, prev_hs = 1'b0;
   logic [11:0] prev_res = 12'd0;
   exp_t       e;
   always @(negedge clk) begin
      if (rst_n && res_valid) begin
         if (prev_valid && !prev_hs)
            check("hold_stable", 32'({res_op, res_flag, res_s}), 32'(prev_res));
         if (res_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 32'({res_op, res_flag, res_s}), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("result", 32'({res_op, res_flag, res_s}), 32'({e.op, e.flag, e.s}));
               hs_q.push_back(cyc);
            end
         end
      end
      prev_valid = rst_n && res_valid;
      prev_hs    = res_valid && res_ready;
      prev_res   = {res_op, res_flag, res_s};
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   logic done = 1'b0;

   initial begin
      // reset without any clock edge
      #1 rst_n = 1'b0;
      #1;
      check("rst_ctrl", 32'({cmd_ready, res_valid, busy, count}), 32'd0);
      check("rst_res",  32'({res_op, res_flag, res_s}), 32'd0);
      check("rst_alu",  32'({alu_op, alu_a, alu_b}), 32'd0);
      repeat (2) sync();
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_ctrl", 32'({cmd_ready, busy, count}), 32'({1'b1, 1'b0, 3'd0}));
      sync();

      // single command latency, no FIFO bypass
      res_ready = 1'b1;
      push(3'b001, 8'h00, 8'h04);
      @(negedge clk);
      check("single_count_p", 32'(count), 32'd1);
      check("single_novalid_p", 32'(res_valid), 32'd0);
      @(negedge clk);
      check("single_issue", 32'({alu_op, alu_a, alu_b, count}), 32'({3'b001, 8'h00, 8'h04, 3'd0}));
      check("single_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("single_novalid_p2", 32'(res_valid), 32'd0);
      @(negedge clk);
      check("single_valid_p3", 32'(res_valid), 32'd1);
      check("single_value", 32'({res_op, res_flag, res_s}), 32'({3'b001, 1'b0, 8'h04}));
      sync();

      // carry and borrow
      push(3'b001, 8'd200, 8'd100);
      push(3'b010, 8'd3, 8'd5);
      wait_drain(30);

      // streaming: three queued, drained with res_ready high
      res_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         push(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      repeat (4) sync();
      hs_q.delete();
      res_ready = 1'b1;
      for (int n = 0; n < 30 && hs_q.size() < 3; n++) @(negedge clk);
      check("stream_count", 32'(hs_q.size()), 32'd3);
      if (hs_q.size() >= 3) begin
         check("stream_gap1", 32'(hs_q[1] - hs_q[0]), 32'd3);
         check("stream_gap2", 32'(hs_q[2] - hs_q[1]), 32'd3);
      end
      sync();
      wait_drain(20);

      // backpressure: five accepted, sixth stalls
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         push(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      @(negedge clk);
      check("bp_count", 32'(count), 32'd4);
      check("bp_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b1; cmd_op = 3'b010; cmd_a = 8'h10; cmd_b = 8'h20;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_stall_ready", 32'(cmd_ready), 32'd0);
         check("bp_stall_count", 32'(count), 32'd4);
      end
      sync();
      res_ready = 1'b1;
      push(3'b010, 8'h10, 8'h20);
      wait_drain(60);
      @(negedge clk);
      check("bp_empty", 32'({busy, count}), 32'd0);
      sync();

      // randomized traffic with random result backpressure
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 2)) sync();
               push(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               res_ready = 1'($urandom_range(0, 1));
               sync();
            end
         end
      join
      res_ready = 1'b1;
      wait_drain(200);

      // asynchronous reset while holding a result
      res_ready = 1'b0;
      push(3'b001, 8'h09, 8'h09);
      repeat (4) sync();
      check("hold_before_rst", 32'(res_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_ctrl", 32'({cmd_ready, res_valid, busy, count}), 32'd0);
      check("rstmid_res",  32'({res_op, res_flag, res_s}), 32'd0);
      check("rstmid_alu",  32'({alu_op, alu_a, alu_b}), 32'd0);
      exp_q.delete();
      sync();
      rst_n = 1'b1;
      @(negedge clk);
      check("rstmid_rel", 32'({cmd_ready, busy, count}), 32'({1'b1, 1'b0, 3'd0}));
      sync();

      // reset one cycle after a pop, result must never appear
      res_ready = 1'b1;
      push(3'b010, 8'd50, 8'd7);
      sync();
      sync();
      rst_n = 1'b0;
      exp_q.delete();
      sync();
      rst_n = 1'b1;
      @(negedge clk);
      check("rstwait_idle", 32'({busy, count}), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rstwait_novalid", 32'(res_valid), 32'd0);
      end

      check("final_queue", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
